uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter. It is the counterpart of the team's 16x-oversampling UART receiver and shares its tick generator and frame format.
- Frame format: start bit, DATA_WIDTH data bits LSB-first, PARITY_WIDTH parity bits, STOP_WIDTH stop bits.
- Sits between the debug/loader control unit (byte source) and the board TX pin. Accepts one byte per request and reports busy/done.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- STOP_WIDTH, 1, stop bits per frame; legal values 1 or 2.
- PARITY_WIDTH, 1, parity bit slots per frame; legal values 1 or 2. Every slot carries the same computed parity bit.
- PARITY_ODD, 0, parity mode: 0 = even parity, 1 = odd parity.
- TICKS_PER_BIT, 16, i_tick pulses per bit period; matches the receiver oversampling.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  one-clock-wide baud x16 enable pulse from the shared baud generator.
- i_tx_start  in  1  request to send i_data_byte; sampled only when o_busy = 0.
- i_data_byte  in  DATA_WIDTH  byte to send; captured in the cycle i_tx_start is accepted.
- o_tx  out  1  serial line, idles high.
- o_busy  out  1  high from the cycle after acceptance through the DONE state.
- o_done_bit  out  1  one-clock pulse at end of frame.

Behaviour:
- Reset (i_reset = 1 at a clock edge):
  - o_tx = 1, o_busy = 0, o_done_bit = 0.
  - State = IDLE; tick, bit-index and parity counters = 0; shift register = 0.
  - Reset mid-frame aborts the frame: the line returns high on the next edge and no done pulse is produced.
- State encoding: one-hot, states IDLE, START_BIT, SENDING, PARITY_BIT, STOP_BIT, DONE. Any illegal encoding goes to IDLE with all outputs in their reset values.
- o_tx is registered, so there are no combinational glitches on the pin.
- IDLE:
  - o_tx = 1.
  - If i_tx_start = 1: latch i_data_byte into the shift register, compute parity, clear the tick counter, go to START_BIT.
  - An i_tick arriving in the acceptance cycle is not counted.
- Parity computation:
  - Even mode: XOR-reduce of the data.
  - Odd mode: inverted XOR-reduce of the data.
  - The value is latched at acceptance; later changes on i_data_byte have no effect.
- Bit timing:
  - Every bit is held for exactly TICKS_PER_BIT i_tick pulses.
  - The tick counter increments only on i_tick.
  - When i_tick arrives with counter = TICKS_PER_BIT-1, the counter clears and the FSM advances.
  - Clocks with no i_tick leave all state unchanged.
- START_BIT: o_tx = 0 for one bit period, then go to SENDING with bit index = 0.
- SENDING:
  - o_tx = data[bit index].
  - At end of bit: index + 1; after index DATA_WIDTH-1, go to PARITY_BIT.
- PARITY_BIT: o_tx = the parity bit for PARITY_WIDTH bit periods, then go to STOP_BIT.
- STOP_BIT: o_tx = 1 for STOP_WIDTH bit periods, then go to DONE.
- DONE:
  - Lasts exactly one clock; o_done_bit = 1, o_tx = 1.
  - Next state is IDLE. All counters clear.
- o_busy = 1 in every state except IDLE.
- i_tx_start while o_busy = 1 is ignored: it is neither queued nor allowed to corrupt the frame.
- Back-to-back frames:
  - i_tx_start may be high in the IDLE cycle immediately after DONE.
  - Minimum line-idle gap between frames is 0 bit periods; the line is only as idle as the DONE and IDLE clocks.
- Frame duration from START_BIT entry to DONE entry is TICKS_PER_BIT*(1+DATA_WIDTH+PARITY_WIDTH+STOP_WIDTH) tick pulses; 176 ticks for the defaults.
- i_tick held high continuously is legal: each clock counts as one tick.
- Internal counter widths: at least 5 bits for ticks, clog2(DATA_WIDTH) bits for the bit index, 2 bits each for the parity and stop indices.

Test Plan:
- Default parameters, tick every 4 clocks, send 0xA5, even parity:
  - Line sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop).
  - Each bit lasts 64 clocks.
  - o_done_bit is a single 1-clock pulse; o_busy falls with the return to IDLE.
- PARITY_ODD=1, send 0x07: parity bit = 0. With PARITY_ODD=0, same byte: parity bit = 1.
- STOP_WIDTH=2, PARITY_WIDTH=2, send 0x00: start 0, eight 0s, two parity 0s, two 1 stop bits; total 208 ticks.
- Pulse i_tx_start with 0x3C, then again with 0xFF mid-frame: only 0x3C is transmitted and no second frame starts. A new start in the cycle after DONE sends the next byte immediately.
- Assert i_reset during data bit 3 of 0x55:
  - o_tx = 1 and o_busy = 0 on the next edge; no o_done_bit pulse.
  - A subsequent 0x55 transmits correctly.
- Loopback o_tx into the team's UART receiver with a shared tick: send 0x00, 0xFF, 0x3C, 0xC3.
  - Receiver o_data_byte matches each byte.
  - Receiver parity output equals the computed even parity.
  - Exactly one receiver done pulse per frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, replicated parity slots, stop bits.
// Bit timing comes from the shared x16 tick; o_tx, o_busy and o_done_bit are all registered.
module uart_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_WIDTH    = 1,
    parameter int PARITY_WIDTH  = 1,
    parameter int PARITY_ODD    = 0,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_tx_start,
    input  logic [DATA_WIDTH-1:0] i_data_byte,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done_bit
);

    localparam int TICK_W = ($clog2(TICKS_PER_BIT) > 5) ? $clog2(TICKS_PER_BIT) : 5;
    localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]        PAR_LAST  = 2'(PARITY_WIDTH - 1);
    localparam logic [1:0]        STOP_LAST = 2'(STOP_WIDTH - 1);

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        START_BIT  = 6'b000010,
        SENDING    = 6'b000100,
        PARITY_BIT = 6'b001000,
        STOP_BIT   = 6'b010000,
        DONE       = 6'b100000
    } state_t;

    state_t                r_state,    w_state_next;
    logic [TICK_W-1:0]     r_tick_cnt, w_tick_next;
    logic [BIT_W-1:0]      r_bit_idx,  w_bit_next;
    logic [1:0]            r_par_idx,  w_par_next;
    logic [1:0]            r_stop_idx, w_stop_next;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_next;
    logic                  r_parity,   w_parity_next;
    logic                  r_tx,       w_tx_next;
    logic                  r_busy,     w_busy_next;
    logic                  r_done,     w_done_next;
    logic                  w_bit_end;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick_cnt;
        w_bit_next    = r_bit_idx;
        w_par_next    = r_par_idx;
        w_stop_next   = r_stop_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_bit_end     = i_tick && (r_tick_cnt == TICK_LAST);

        if (i_tick) begin
            w_tick_next = w_bit_end ? '0 : r_tick_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_tick_next = '0;
                w_bit_next  = '0;
                w_par_next  = '0;
                w_stop_next = '0;
                if (i_tx_start) begin
                    w_shift_next  = i_data_byte;
                    w_parity_next = (^i_data_byte) ^ (PARITY_ODD != 0);
                    w_state_next  = START_BIT;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = SENDING;
                end
            end
            SENDING: begin
                // Data leaves from bit 0 of the shift register, so a shift exposes the next bit.
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == BIT_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = PARITY_BIT;
                    end else begin
                        w_bit_next = r_bit_idx + 1'b1;
                    end
                end
            end
            PARITY_BIT: begin
                if (w_bit_end) begin
                    if (r_par_idx == PAR_LAST) begin
                        w_par_next   = '0;
                        w_state_next = STOP_BIT;
                    end else begin
                        w_par_next = r_par_idx + 1'b1;
                    end
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_stop_next  = '0;
                        w_state_next = DONE;
                    end else begin
                        w_stop_next = r_stop_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                w_tick_next  = '0;
                w_bit_next   = '0;
                w_par_next   = '0;
                w_stop_next  = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_tick_next   = '0;
                w_bit_next    = '0;
                w_par_next    = '0;
                w_stop_next   = '0;
                w_shift_next  = '0;
                w_parity_next = 1'b0;
                w_state_next  = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pin changes with the state.
        w_tx_next   = 1'b1;
        w_busy_next = 1'b1;
        w_done_next = 1'b0;
        case (w_state_next)
            IDLE:       w_busy_next = 1'b0;
            START_BIT:  w_tx_next   = 1'b0;
            SENDING:    w_tx_next   = w_shift_next[0];
            PARITY_BIT: w_tx_next   = w_parity_next;
            DONE:       w_done_next = 1'b1;
            default:    w_tx_next   = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_par_idx  <= '0;
            r_stop_idx <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_idx  <= w_bit_next;
            r_par_idx  <= w_par_next;
            r_stop_idx <= w_stop_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_done_bit = r_done;

endmodule
